// File: rtl/hht_pkg.sv
// hht_pkg: shared types and constants for the HHT row accumulator.
//   HHT_ACC_W  : default accumulator/result width
//   HHT_ADDR_W : result-memory word address width
//   hht_state_e: control FSM states
//   result_t   : one (address, dot-product) result as stored in the result FIFO
package hht_pkg;

    localparam int unsigned HHT_ACC_W  = 32;
    localparam int unsigned HHT_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hht_state_e;

    typedef struct packed {
        logic [HHT_ADDR_W-1:0] addr;
        logic [HHT_ACC_W-1:0]  data;
    } result_t;

endpackage

// File: rtl/hht_result_fifo.sv
// hht_result_fifo: synchronous FIFO of result_t with an occupancy count.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset (clears pointers and count)
//   push_i  : write din_i; the caller never pushes into a full FIFO unless
//             it pops in the same cycle
//   din_i   : result to write
//   pop_i   : remove the head entry (ignored when empty)
//   dout_o  : head entry (meaningful only when !empty_o)
//   empty_o : FIFO holds no entries
//   count_o : number of entries held, 0..DEPTH
module hht_result_fifo
    import hht_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  result_t                  din_i,
    input  logic                     pop_i,
    output result_t                  dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    result_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    cnt_q;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/hht_row_accumulator.sv
// hht_row_accumulator: CSR SpMV row accumulator fed by the HHT control stage.
// Multiplies each (matrix value, vector value) beat, accumulates per row and
// writes one (result_base + row, dot product) result per row through a
// buffered valid/ready port.
//
// Ports:
//   clk_i, rst_ni        : clock (rising edge), synchronous active-low reset
//   start_i              : one-cycle pulse in IDLE; latches result_base_i/num_rows_i
//   result_base_i        : word address of y[0]
//   num_rows_i           : number of rows to process
//   in_valid_i/in_ready_o: beat handshake from the control stage
//   in_mval_i, in_vval_i : matrix nonzero and matching vector element
//   in_last_i            : beat is the last nonzero of its row
//   in_empty_i           : row has no nonzeros (wins over in_last_i)
//   out_valid_o/out_ready_i, out_addr_o, out_data_o : result write port
//   busy_o               : high in RUN and DRAIN
//   done_o               : one-cycle pulse once every row has been written out
//
// Build option: define HHT_ACC_SAT_EN to saturate products and sums at
// 2^ACC_W-1 and keep a sticky internal overflow flag (cleared by start).
// Without it all arithmetic wraps modulo 2^ACC_W.
//
// ACC_W must equal hht_pkg::HHT_ACC_W, since result_t carries the data field.
module hht_row_accumulator
    import hht_pkg::*;
#(
    parameter int unsigned ACC_W      = HHT_ACC_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           result_base_i,
    input  logic [31:0]           num_rows_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_mval_i,
    input  logic [DATA_W-1:0]     in_vval_i,
    input  logic                  in_last_i,
    input  logic                  in_empty_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_addr_o,
    output logic [ACC_W-1:0]      out_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- control state ----------------
    hht_state_e      state_q;
    logic [31:0]     base_q;
    logic [31:0]     nrows_q;
    logic [31:0]     row_cnt_q;
    logic            busy_q;
    logic            done_q;

    // ---------------- S1 registers ----------------
    logic            s1_vld_q;
    logic            s1_last_q;
    logic            s1_empty_q;
    logic [ACC_W-1:0] s1_prod_q;
    logic [31:0]     s1_addr_q;

    // ---------------- S2 / accumulator ----------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] prod_w;
    logic [ACC_W-1:0] sum_w;

    // ---------------- FIFO interface ----------------
    logic            push;
    logic            pop;
    result_t         push_data;
    result_t         head;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;

    logic            accept;
    logic            row_end_in;
    logic            s1_end;
    logic [CW:0]     committed;

    assign accept     = in_valid_i && in_ready_o;
    assign row_end_in = in_last_i || in_empty_i;
    assign s1_end     = s1_vld_q && (s1_last_q || s1_empty_q);

    // Every row end already in S1 will land in the FIFO next edge, so it is
    // counted as occupied; this keeps the FIFO from ever overflowing.
    assign committed  = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_end};
    assign in_ready_o = (state_q == RUN) && (committed < (CW+1)'(FIFO_DEPTH));

`ifdef HHT_ACC_SAT_EN
    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0]   prod_full;
    logic            prod_ovf;
    logic [ACC_W:0]  sum_full;
    logic            sum_ovf;
    logic            ovf_q;

    assign prod_full = PW'(in_mval_i) * PW'(in_vval_i);
    assign prod_ovf  = (prod_full > PW'({ACC_W{1'b1}}));
    assign prod_w    = prod_ovf ? {ACC_W{1'b1}} : prod_full[ACC_W-1:0];

    assign sum_full  = {1'b0, acc_q} + {1'b0, s1_prod_q};
    assign sum_ovf   = sum_full[ACC_W];
    assign sum_w     = sum_ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];

    // Sticky: any saturated product or sum since the last start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            ovf_q <= 1'b0;
        end else if ((accept && !in_empty_i && prod_ovf) ||
                     (s1_vld_q && !s1_empty_q && sum_ovf)) begin
            ovf_q <= 1'b1;
        end
    end
`else
    // Operands are reduced to ACC_W first; the result is still the product
    // modulo 2^ACC_W, without carrying unused high bits around.
    assign prod_w = ACC_W'(in_mval_i) * ACC_W'(in_vval_i);
    assign sum_w  = acc_q + s1_prod_q;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            base_q    <= '0;
            nrows_q   <= '0;
            row_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q    <= result_base_i;
                        nrows_q   <= num_rows_i;
                        row_cnt_q <= '0;
                        if (num_rows_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept && row_end_in) begin
                        row_cnt_q <= row_cnt_q + 32'd1;
                        if (row_cnt_q + 32'd1 == nrows_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_vld_q && fifo_empty) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ---------------- S1: multiply and capture row info ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_empty_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_addr_q  <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_prod_q  <= prod_w;
                s1_last_q  <= in_last_i;
                s1_empty_q <= in_empty_i;
                s1_addr_q  <= base_q + row_cnt_q;
            end
        end
    end

    // ---------------- S2: accumulate and emit row results ----------------
    always_comb begin
        acc_d          = acc_q;
        push           = s1_end;
        push_data.addr = s1_addr_q;
        push_data.data = s1_empty_q ? '0 : sum_w;
        // An empty row leaves acc alone; it is already zero between rows.
        if (s1_vld_q && !s1_empty_q) begin
            acc_d = s1_last_q ? '0 : sum_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    hht_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // ---------------- output port ----------------
    assign out_valid_o = !fifo_empty;
    assign pop         = out_valid_o && out_ready_i;
    // Zero when empty so the port is deterministic after reset.
    assign out_addr_o  = fifo_empty ? '0 : head.addr;
    assign out_data_o  = fifo_empty ? '0 : head.data;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_hht_row_accumulator.sv
// tb_hht_row_accumulator: directed self-checking bench for hht_row_accumulator.
module tb_hht_row_accumulator;
    import hht_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] result_base;
    logic [31:0] num_rows;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mval;
    logic [31:0] in_vval;
    logic        in_last;
    logic        in_empty;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hht_row_accumulator dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .result_base_i (result_base),
        .num_rows_i    (num_rows),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_mval_i     (in_mval),
        .in_vval_i     (in_vval),
        .in_last_i     (in_last),
        .in_empty_i    (in_empty),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_addr_o    (out_addr),
        .out_data_o    (out_data),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [31:0] n);
        start       = 1'b1;
        result_base = base;
        num_rows    = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] m, input logic [31:0] v,
                        input logic l, input logic e);
        int n = 0;
        in_valid = 1'b1;
        in_mval  = m;
        in_vval  = v;
        in_last  = l;
        in_empty = e;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_addr"},  64'(out_addr),  64'(ea));
        chk({tag, "_data"},  64'(out_data),  64'(ed));
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; result_base = '0; num_rows = '0;
        in_valid = 1'b0; in_mval = '0; in_vval = '0; in_last = 1'b0;
        in_empty = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_out_addr",  64'(out_addr),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        rst_n = 1'b1;
        tick();

        // Row 0 of the 32x32 benchmark: 25*24 + 94*73 + 78*50 = 11362
        start_run(32'd40000, 32'd1);
        chk("t1_busy",     64'(busy),     64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        send(32'd25, 32'd24, 1'b0, 1'b0);
        send(32'd94, 32'd73, 1'b0, 1'b0);
        send(32'd78, 32'd50, 1'b1, 1'b0);
        chk("t1_ready_drop", 64'(in_ready),  64'd0);
        chk("t1_no_out_yet", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_addr",  64'(out_addr),  64'd40000);
        chk("t1_data",  64'(out_data),  64'd11362);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_popped",    64'(out_valid), 64'd0);
        chk("t1_done_wait", 64'(done),      64'd0);
        tick();
        chk("t1_done",      64'(done),      64'd1);
        chk("t1_busy_off",  64'(busy),      64'd0);
        tick();
        chk("t1_done_pulse", 64'(done),     64'd0);

        // Empty rows; a stray start while running must be ignored
        start_run(32'd40000, 32'd3);
        send(32'd0, 32'd0, 1'b0, 1'b1);
        start_run(32'd999, 32'd0);
        send(32'd5, 32'd6, 1'b1, 1'b0);
        send(32'd9, 32'd9, 1'b1, 1'b1);
        collect("t2_r0", 32'd40000, 32'd0);
        collect("t2_r1", 32'd40001, 32'd30);
        collect("t2_r2", 32'd40002, 32'd0);
        wait_done("t2");

        // Backpressure: four rows fill the FIFO, the rest wait for drain
        start_run(32'd40000, 32'd6);
        for (int i = 0; i < 4; i++) send(32'd2, 32'd3, 1'b1, 1'b0);
        chk("t3_ready_drop", 64'(in_ready), 64'd0);
        repeat (3) tick();
        chk("t3_still_held", 64'(in_ready), 64'd0);
        chk("t3_head_addr",  64'(out_addr), 64'd40000);
        fork
            begin
                send(32'd2, 32'd3, 1'b1, 1'b0);
                send(32'd2, 32'd3, 1'b1, 1'b0);
            end
            begin
                for (int k = 0; k < 6; k++)
                    collect($sformatf("t3_r%0d", k), 32'd40000 + 32'(k), 32'd6);
            end
        join
        wait_done("t3");

        // num_rows == 0
        start_run(32'd5, 32'd0);
        chk("t4_done",    64'(done),      64'd1);
        chk("t4_no_out",  64'(out_valid), 64'd0);
        tick();
        chk("t4_done_off", 64'(done),     64'd0);
        chk("t4_no_out2",  64'(out_valid), 64'd0);

        // Reset during RUN with two results buffered and a partial sum in flight
        start_run(32'd200, 32'd4);
        send(32'd1, 32'd1, 1'b1, 1'b0);
        send(32'd2, 32'd2, 1'b1, 1'b0);
        send(32'd7, 32'd7, 1'b0, 1'b0);
        tick();
        chk("t5_buffered", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy",  64'(busy),      64'd0);
        chk("t5_rst_ready", 64'(in_ready),  64'd0);
        rst_n = 1'b1;
        tick();
        start_run(32'd100, 32'd1);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        send(32'd5, 32'd6, 1'b1, 1'b0);
        collect("t5_fresh", 32'd100, 32'd42);
        wait_done("t5");

        // Product overflow
        start_run(32'd7, 32'd1);
        send(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
`ifdef HHT_ACC_SAT_EN
        collect("t6_ovf", 32'd7, 32'hFFFF_FFFF);
`else
        collect("t6_ovf", 32'd7, 32'hFFFF_FFFE);
`endif
        wait_done("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hht_row_accumulator.md
Name: hht_row_accumulator

Overview:
- Downstream consumer of the HHT `control` stage in the CSR sparse matrix × dense vector engine.
- `control` walks row pointers, column indices and matrix values, and fetches vector elements. It hands this block one beat per nonzero: a matrix value, the matching vector value, and row-boundary flags.
- This block multiplies each pair, accumulates per row, and emits one (address, dot-product) result per row through a buffered valid/ready write port toward result memory.

Parameters:
- ACC_W, 32, accumulator and result width in bits.
- DATA_W, 32, width of in_mval and in_vval.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; latches result_base and num_rows.
- result_base  input  32  word address of y[0].
- num_rows  input  32  rows to process.
- in_valid  input  1  beat valid from control stage.
- in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
- in_mval  input  DATA_W  matrix nonzero value.
- in_vval  input  DATA_W  vector element v[col].
- in_last  input  1  beat is the last nonzero of its row.
- in_empty  input  1  row has no nonzeros; mval/vval ignored.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_addr  output  32  result_base + row index.
- out_data  output  ACC_W  row dot product.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when all rows have been written out.

Behaviour:
- Reset (Rst==0 at edge):
  - state=IDLE; accumulator, row counter, pipeline valids and FIFO pointers cleared.
  - in_ready, out_valid, busy, done = 0; out_addr, out_data = 0.
  - Reset mid-operation discards all in-flight and buffered results.
- States IDLE, RUN, DRAIN, DONE:
  - IDLE: on start, latch result_base and num_rows, row_cnt=0. Go to RUN, or to DONE if num_rows==0. start is ignored outside IDLE.
  - RUN: accept beats. row_cnt increments on each accepted beat with in_last or in_empty. When the increment makes row_cnt==num_rows, go to DRAIN at that edge; in_ready drops the next cycle.
  - DRAIN: in_ready=0. When pipeline stages are empty and the FIFO is empty, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Pipeline:
  - S1 registers product = in_mval*in_vval, truncated to ACC_W (modulo 2^ACC_W), plus the last/empty flags and the row index.
  - S2 adds the product to acc.
    - On a last beat: push acc+product into the FIFO and clear acc to 0.
    - On an empty beat: push 0 and leave acc untouched (it is already 0).
  - in_empty takes precedence over in_last.
- Latency: a last beat accepted at edge N is written to the FIFO at edge N+1. With the FIFO empty, out_valid is high in the cycle after edge N+1.
- Arithmetic: unsigned; the accumulator wraps modulo 2^ACC_W.
- Backpressure: in_ready = RUN && (fifo_count + row-end beats in S1) < FIFO_DEPTH. This guarantees the FIFO never overflows.
- Output handshake:
  - out_valid mirrors FIFO not-empty; out_addr and out_data are the FIFO head.
  - Pop on out_valid && out_ready.
  - out_addr/out_data stay stable while out_valid && !out_ready.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Results leave in row order. Beats arriving in IDLE/DRAIN/DONE are not accepted (in_ready=0).

Optional Feature:
- Macro: HHT_ACC_SAT_EN.
- Defined: product and accumulation saturate at 2^ACC_W−1; a sticky internal ovf flag is set and cleared by start.
- Undefined: modulo wrap, no flag logic.

Decomposition:
- Package hht_pkg:
  - ACC_W default constant.
  - typedef enum of IDLE/RUN/DRAIN/DONE.
  - packed struct result_t {addr[31:0], data[ACC_W-1:0]}.
- Sub-module: hht_result_fifo (synchronous FIFO of result_t, with count output). It is instantiated once.

Test Plan:
- Row 0 from the 32×32 benchmark, result_base=40000, num_rows=1:
  - Stimulus: beats (25,24), (94,73), (78,50 last).
  - Response: out_addr=40000, out_data=11362; done one cycle after the pop.
- Empty rows, num_rows=3:
  - Stimulus: empty, (5,6 last), empty.
  - Response: results (40000,0), (40001,30), (40002,0) in order.
- Backpressure:
  - Stimulus: out_ready=0, 6 single-beat rows (2,3 last).
  - Response: in_ready drops once the 4 FIFO slots are committed; nothing is lost. After out_ready=1, six results of 6 appear at consecutive addresses.
- num_rows=0 with start:
  - Response: DONE next cycle, done pulses, no out_valid.
- Reset mid-operation:
  - Stimulus: Rst low during RUN with 2 results buffered.
  - Response: next cycle out_valid=0, busy=0, in_ready=0. A fresh start then produces correct sums from acc=0.
- Overflow, ACC_W=32:
  - Stimulus: beats (0xFFFF_FFFF,2 last).
  - Response: 0xFFFF_FFFE without HHT_ACC_SAT_EN; 0xFFFF_FFFF with it.
